fifo_drain_wr: RTL
==================

Name: fifo_drain_wr

Overview:
- Consumer-side engine for the team's synchronous FIFO: pops words from the FIFO read port and writes them to consecutive addresses of a single-port SRAM-style write interface.
- Started by a start/length command; reports busy, done and a written-word count.
- Sits between the FIFO read side and local data memory, so firmware can drain a block of N words without per-word handshaking.

Parameters:
- WIDTH, 32: data word width (matches FIFO WIDTH).
- ADDR_WIDTH, 10: memory address width; addresses wrap modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first memory address, latched on accepted start.
- len  in  ADDR_WIDTH+1  number of words to transfer (0..2^ADDR_WIDTH), latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the transfer is complete.
- word_count  out  ADDR_WIDTH+1  words accepted by memory in the current or last transfer.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO head word, valid whenever fifo_empty=0 (first-word fall-through).
- fifo_r_ready  out  1  pop request; the FIFO pops at the rising edge where fifo_r_ready=1 and fifo_empty=0.
- mem_we  out  1  write request, held until accepted.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  WIDTH  write data.
- mem_ready  in  1  memory accepts the write at the rising edge where mem_we=1 and mem_ready=1.

Behaviour:
- Reset (async, takes effect immediately): state=IDLE; busy=0, done=0, fifo_r_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0. Internal wr_ptr and remaining are cleared.
- Reset mid-transfer aborts the transfer. Words already popped but not written are discarded. No done pulse is generated.
- States:
  - IDLE -> RUN on start=1. At that edge, latch wr_ptr=start_addr and remaining=len; clear word_count; busy=1 from the next cycle.
  - RUN -> DONE when remaining=0 and the output stage is empty or being accepted this edge.
  - DONE -> IDLE unconditionally. done=1 and busy=0 only while in DONE.
- start while busy or in DONE is ignored.
- len=0: IDLE -> RUN -> DONE. fifo_r_ready and mem_we are never asserted; done pulses 2 cycles after start.
- One-entry output stage (mem_we/mem_addr/mem_wdata registers):
  - fifo_r_ready is combinational: (state==RUN) & (remaining!=0) & !fifo_empty & (!mem_we | mem_ready). It never asserts while fifo_empty=1.
  - Pop edge: mem_wdata<=fifo_data, mem_addr<=wr_ptr, mem_we<=1, wr_ptr<=wr_ptr+1 (mod 2^ADDR_WIDTH), remaining<=remaining-1.
  - Accept edge without a simultaneous pop: mem_we<=0. Address and data hold their last values.
  - Simultaneous accept and pop: mem_we stays 1 and is loaded with the new word. Throughput is 1 word/cycle when the FIFO is non-empty and mem_ready=1.
  - word_count increments on every accept edge and holds its value after done until the next accepted start.
- Latency: the first word is presented on mem_* 1 cycle after its pop edge. The earliest first pop is the cycle after start.
- Memory backpressure (mem_ready=0): mem_we, mem_addr and mem_wdata hold stable; no further pop occurs.
- FIFO underflow: the engine stalls in RUN indefinitely while fifo_empty=1. There is no timeout.
- Address wrap: start_addr=2^ADDR_WIDTH-2 with len=4 writes addresses 1022, 1023, 0, 1.
- Exactly len pops occur per transfer; the engine never pops beyond len even when the FIFO holds more words.

Test Plan:
- Basic drain: FIFO preloaded with 3 words 0,1,2; start_addr=5, len=3, mem_ready=1. Required: writes (5,0), (6,1), (7,2) on consecutive cycles; done pulses once; word_count=3; the FIFO still holds any extra words.
- Backpressure: len=4 with mem_ready toggled 0/1 every cycle. Required: mem_addr and mem_wdata are stable while mem_ready=0; no pop occurs while the stage is full and unaccepted; all 4 words reach memory in order; word_count=4.
- Starved FIFO: start with len=4 and an empty FIFO, then push a word every 3 cycles. Required: fifo_r_ready stays 0 while fifo_empty=1; busy=1 throughout; done arrives only after the 4th write.
- Wrap and len=0: start_addr=1022, len=4 gives addresses 1022, 1023, 0, 1. len=0 gives done 2 cycles after start, with no mem_we and no pop.
- Reset and ignored start: pulse start during RUN, which must be ignored. Then assert reset after 2 of 5 words. Required: all outputs are 0 immediately with no done pulse; a new start after reset transfers correctly.
- Random: 600 iterations of random len (0..8), random FIFO fill and random mem_ready. A scoreboard compares memory contents against a reference queue model; zero mismatches required.

Source files
------------

// File: rtl/fifo_drain_wr.sv
// Drains a fixed number of words from a first-word-fall-through FIFO into
// consecutive addresses of a single-port write interface through a one-entry output stage.
module fifo_drain_wr #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_count,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_data,
    output logic                  fifo_r_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]      DATA_ZERO = {WIDTH{1'b0}};

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  pop_s;
    logic                  accept_s;

    // A pop is only allowed when the output stage is free or draining this edge.
    assign pop_s    = (state_q == ST_RUN) && (remaining_q != CNT_ZERO) && !fifo_empty
                      && (!mem_we_q || mem_ready);
    assign accept_s = mem_we_q && mem_ready;

    // Next-state logic for the control FSM, pointers and output stage.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        wr_ptr_d     = wr_ptr_q;
        remaining_d  = remaining_q;
        word_count_d = word_count_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    busy_d       = 1'b1;
                    wr_ptr_d     = start_addr;
                    remaining_d  = len;
                    word_count_d = CNT_ZERO;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (pop_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q;
                    mem_wdata_d = fifo_data;
                    wr_ptr_d    = wr_ptr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                end else if (accept_s) begin
                    mem_we_d = 1'b0;
                end else begin
                    mem_we_d = mem_we_q;
                end
                if (accept_s) begin
                    word_count_d = word_count_q + CNT_ONE;
                end else begin
                    word_count_d = word_count_q;
                end
                if ((remaining_q == CNT_ZERO) && (!mem_we_q || mem_ready)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any word held in the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_ptr_q     <= ADDR_ZERO;
            remaining_q  <= CNT_ZERO;
            word_count_q <= CNT_ZERO;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= ADDR_ZERO;
            mem_wdata_q  <= DATA_ZERO;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wr_ptr_q     <= wr_ptr_d;
            remaining_q  <= remaining_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign word_count   = word_count_q;
    assign fifo_r_ready = pop_s;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
